// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types for the ALU issue stage
// default widths, the buffered command bundle and the FSM states
package alu_issue_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESULT
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO of cmd_t
// pointers carry one extra wrap bit to tell full from empty
module alu_cmd_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     wdata,
    input  logic                     pop,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    cmd_t        mem [DEPTH];

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

    // pointer update; push and pop may share an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issues buffered commands to the combinational
// ALU and hands each captured result downstream with op and tag
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int OPW    = OP_W,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int TAGW   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [OPW-1:0]         cmd_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [WIDTH-1:0]       alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [OPW-1:0]         res_op,
    output logic [TAGW-1:0]        res_tag,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    cmd_t          wcmd;
    cmd_t          head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          done;

    assign wcmd.op   = cmd_op;
    assign wcmd.a    = cmd_a;
    assign wcmd.b    = cmd_b;

    assign cmd_ready = rst_n & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign done      = (state == DRIVE) & (cnt == LAST);
    assign pop       = ~empty & ((state == IDLE) |
                                 ((state == RESULT) & res_ready));
    assign busy      = (state != IDLE) | ~empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // sequencing: load on pop, settle in DRIVE, hold in RESULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (pop) state <= DRIVE;
                DRIVE:   if (done) state <= RESULT;
                RESULT:  if (res_ready) state <= pop ? DRIVE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // settle counter: cleared on each load, counts while driving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= '0;
        end else if (state == DRIVE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // operand registers: held between loads so the ALU sees stable inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (pop) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
        end
    end

    // result capture at end of settle; tag advances on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_tag   <= '0;
        end else if (done) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_op    <= alu_op;
        end else if ((state == RESULT) && res_ready) begin
            res_valid <= 1'b0;
            res_tag   <= res_tag + 1'b1;
        end
    end

endmodule
